letter_pool: RTL and testbench

//   Falling-letter object table for the typing game. Consumes the letter generator's
//   ch/speed/x/y stream; spawns letters into a fixed pool of slots, moves them down

---
 rtl/letter_pool.sv | 203 ++++++++++++++++++++
 tb/tb_letter_pool.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/letter_pool.sv
// Falling-letter object table: spawns generator letters into a fixed slot pool, moves them
// down once per frame, removes them on a matching keypress (hit) or at the bottom row (miss).
module letter_pool #(
    parameter int unsigned SLOTS        = 8,
    parameter logic [8:0]  BOTTOM       = 9'd456,
    parameter int unsigned SPAWN_PERIOD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [7:0]  gen_ch,
    input  logic [2:0]  gen_speed,
    input  logic [8:0]  gen_x,
    input  logic [9:0]  gen_y,
    input  logic        key_valid,
    input  logic [7:0]  key_ch,
    input  logic [3:0]  rd_idx,
    output logic        rd_active,
    output logic [7:0]  rd_ch,
    output logic [8:0]  rd_x,
    output logic [9:0]  rd_y,
    output logic        hit_pulse,
    output logic        wrong_pulse,
    output logic        miss_pulse,
    output logic        drop_pulse,
    output logic [15:0] score,
    output logic [7:0]  misses
);

    localparam int unsigned CntW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    logic            active_q [SLOTS];
    logic            active_d [SLOTS];
    logic [7:0]      ch_q     [SLOTS];
    logic [7:0]      ch_d     [SLOTS];
    logic [2:0]      speed_q  [SLOTS];
    logic [2:0]      speed_d  [SLOTS];
    logic [8:0]      x_q      [SLOTS];
    logic [8:0]      x_d      [SLOTS];
    logic [9:0]      y_q      [SLOTS];
    logic [9:0]      y_d      [SLOTS];
    logic [9:0]      sum      [SLOTS];

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     score_q, score_d;
    logic [7:0]      misses_q, misses_d;
    logic            hit_q, hit_d;
    logic            wrong_q, wrong_d;
    logic            miss_q, miss_d;
    logic            drop_q, drop_d;

    logic [7:0]      folded_key;
    logic            hit_found;
    logic [3:0]      hit_idx;
    logic [8:0]      best_x;
    logic            hit;
    logic            free_found;
    logic [3:0]      free_idx;
    logic            spawn_now;
    logic [4:0]      miss_cnt;
    logic [8:0]      misses_sum;

    for (genvar g = 0; g < SLOTS; g++) begin : g_sum
        assign sum[g] = {1'b0, x_q[g]} + {7'd0, speed_q[g]};
    end

    // Key match: lowest index wins ties because only a strictly larger x displaces the pick.
    always_comb begin
        folded_key = key_ch;
        if (key_ch >= 8'h61 && key_ch <= 8'h7a) begin
            folded_key = key_ch & 8'hdf;
        end
        hit_found = 1'b0;
        hit_idx   = '0;
        best_x    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (active_q[i] && ch_q[i] == folded_key && (!hit_found || x_q[i] > best_x)) begin
                hit_found = 1'b1;
                hit_idx   = 4'(i);
                best_x    = x_q[i];
            end
        end
        hit = key_valid && hit_found;

        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!active_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    assign spawn_now = frame_tick && (cnt_q == CntW'(SPAWN_PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (frame_tick) begin
            cnt_d = spawn_now ? '0 : cnt_q + 1'b1;
        end

        miss_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            active_d[i] = active_q[i];
            ch_d[i]     = ch_q[i];
            speed_d[i]  = speed_q[i];
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            if (hit && hit_idx == 4'(i)) begin
                active_d[i] = 1'b0;
                ch_d[i]     = '0;
                speed_d[i]  = '0;
                x_d[i]      = '0;
                y_d[i]      = '0;
            end else if (frame_tick && active_q[i]) begin
                if (sum[i] >= {1'b0, BOTTOM}) begin
                    active_d[i] = 1'b0;
                    ch_d[i]     = '0;
                    speed_d[i]  = '0;
                    x_d[i]      = '0;
                    y_d[i]      = '0;
                    miss_cnt    = miss_cnt + 5'd1;
                end else begin
                    x_d[i] = sum[i][8:0];
                end
            end
            // Target was inactive at cycle start, so it cannot also be hit or moved here.
            if (spawn_now && free_found && free_idx == 4'(i)) begin
                active_d[i] = 1'b1;
                ch_d[i]     = gen_ch;
                speed_d[i]  = (gen_speed == 3'd0) ? 3'd1 : gen_speed;
                x_d[i]      = gen_x;
                y_d[i]      = gen_y;
            end
        end

        score_d    = (hit && score_q != 16'hffff) ? score_q + 16'd1 : score_q;
        misses_sum = {1'b0, misses_q} + {4'd0, miss_cnt};
        misses_d   = misses_sum[8] ? 8'hff : misses_sum[7:0];
        hit_d      = hit;
        wrong_d    = key_valid && !hit_found;
        miss_d     = (miss_cnt != 5'd0);
        drop_d     = spawn_now && !free_found;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                active_q[i] <= 1'b0;
                ch_q[i]     <= '0;
                speed_q[i]  <= '0;
                x_q[i]      <= '0;
                y_q[i]      <= '0;
            end
            cnt_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            wrong_q  <= 1'b0;
            miss_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                active_q[i] <= active_d[i];
                ch_q[i]     <= ch_d[i];
                speed_q[i]  <= speed_d[i];
                x_q[i]      <= x_d[i];
                y_q[i]      <= y_d[i];
            end
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            wrong_q  <= wrong_d;
            miss_q   <= miss_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        rd_active = 1'b0;
        rd_ch     = '0;
        rd_x      = '0;
        rd_y      = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_active = active_q[i];
                rd_ch     = ch_q[i];
                rd_x      = x_q[i];
                rd_y      = y_q[i];
            end
        end
    end

    assign hit_pulse   = hit_q;
    assign wrong_pulse = wrong_q;
    assign miss_pulse  = miss_q;
    assign drop_pulse  = drop_q;
    assign score       = score_q;
    assign misses      = misses_q;

endmodule

// File: tb/tb_letter_pool.sv
// Directed bench for letter_pool with a 4-slot pool and a spawn attempt every second frame.
module tb_letter_pool;

    localparam int unsigned SLOTS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  gen_ch = '0;
    logic [2:0]  gen_speed = '0;
    logic [8:0]  gen_x = '0;
    logic [9:0]  gen_y = '0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_ch = '0;
    logic [3:0]  rd_idx = '0;
    logic        rd_active;
    logic [7:0]  rd_ch;
    logic [8:0]  rd_x;
    logic [9:0]  rd_y;
    logic        hit_pulse, wrong_pulse, miss_pulse, drop_pulse;
    logic [15:0] score;
    logic [7:0]  misses;

    int n_checks = 0;
    int n_errors = 0;

    letter_pool #(
        .SLOTS       (SLOTS),
        .BOTTOM      (9'd456),
        .SPAWN_PERIOD(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .gen_ch     (gen_ch),
        .gen_speed  (gen_speed),
        .gen_x      (gen_x),
        .gen_y      (gen_y),
        .key_valid  (key_valid),
        .key_ch     (key_ch),
        .rd_idx     (rd_idx),
        .rd_active  (rd_active),
        .rd_ch      (rd_ch),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .hit_pulse  (hit_pulse),
        .wrong_pulse(wrong_pulse),
        .miss_pulse (miss_pulse),
        .drop_pulse (drop_pulse),
        .score      (score),
        .misses     (misses)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(input logic ft, input logic kv, input logic [7:0] kc);
        @(negedge clk);
        frame_tick = ft;
        key_valid  = kv;
        key_ch     = kc;
        @(negedge clk);
        frame_tick = 1'b0;
        key_valid  = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic set_gen(input logic [7:0] c, input logic [2:0] s, input logic [8:0] x,
                           input logic [9:0] y);
        gen_ch    = c;
        gen_speed = s;
        gen_x     = x;
        gen_y     = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_slot(input string tag, input logic [3:0] idx, input logic act,
                              input logic [7:0] c, input logic [8:0] x);
        rd_idx = idx;
        #1;
        check({tag, ".active"}, 32'(rd_active), 32'(act));
        if (act) begin
            check({tag, ".ch"}, 32'(rd_ch), 32'(c));
            check({tag, ".x"}, 32'(rd_x), 32'(x));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst.score", 32'(score), 32'd0);
        check("rst.misses", 32'(misses), 32'd0);
        check("rst.pulses", {28'd0, hit_pulse, wrong_pulse, miss_pulse, drop_pulse}, 32'd0);
        check_slot("rst.s0", 4'd0, 1'b0, 8'h00, 9'd0);

        // Spawn then move
        set_gen("K", 3'd2, 9'd0, 10'd90);
        tick();
        check_slot("t1.tick1.s0", 4'd0, 1'b0, 8'h00, 9'd0);
        tick();
        check_slot("t1.spawn.s0", 4'd0, 1'b1, "K", 9'd0);
        check("t1.spawn.y", 32'(rd_y), 32'd90);
        tick();
        check_slot("t1.move.s0", 4'd0, 1'b1, "K", 9'd2);
        check_slot("t1.s1", 4'd1, 1'b0, 8'h00, 9'd0);

        // Reaching the bottom
        do_reset();
        set_gen("K", 3'd2, 9'd454, 10'd0);
        tick();
        tick();
        check_slot("t2.spawn.s0", 4'd0, 1'b1, "K", 9'd454);
        tick();
        check("t2.miss_pulse", 32'(miss_pulse), 32'd1);
        check("t2.misses", 32'(misses), 32'd1);
        check_slot("t2.cleared.s0", 4'd0, 1'b0, 8'h00, 9'd0);
        step(1'b0, 1'b0, 8'h00);
        check("t2.miss_pulse.drop", 32'(miss_pulse), 32'd0);

        // Key hits prefer the lowest letter on screen
        do_reset();
        set_gen("Q", 3'd1, 9'd34, 10'd0);
        tick(); tick();
        set_gen("A", 3'd1, 9'd0, 10'd0);
        tick(); tick();
        set_gen("B", 3'd1, 9'd0, 10'd0);
        tick(); tick();
        set_gen("Q", 3'd1, 9'd120, 10'd0);
        tick(); tick();
        check_slot("t3.s0", 4'd0, 1'b1, "Q", 9'd40);
        check_slot("t3.s3", 4'd3, 1'b1, "Q", 9'd120);
        step(1'b0, 1'b1, "q");
        check("t3.hit_pulse", 32'(hit_pulse), 32'd1);
        check("t3.score", 32'(score), 32'd1);
        check_slot("t3.hit.s3", 4'd3, 1'b0, 8'h00, 9'd0);
        check_slot("t3.keep.s0", 4'd0, 1'b1, "Q", 9'd40);
        step(1'b0, 1'b1, "Z");
        check("t3.wrong_pulse", 32'(wrong_pulse), 32'd1);
        check("t3.wrong.hit_pulse", 32'(hit_pulse), 32'd0);
        check("t3.wrong.score", 32'(score), 32'd1);
        step(1'b0, 1'b1, "q");
        check("t3.second.score", 32'(score), 32'd2);
        check_slot("t3.second.s0", 4'd0, 1'b0, 8'h00, 9'd0);

        // Full pool: drop, then hit with a same-cycle spawn attempt
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_gen(8'h41 + 8'(k), 3'd1, 9'd0, 10'(k * 10));
            tick(); tick();
        end
        for (int k = 0; k < 4; k++) begin
            check_slot("t4.full", 4'(k), 1'b1, 8'h41 + 8'(k), 9'(6 - 2 * k));
        end
        set_gen("Z", 3'd1, 9'd0, 10'd0);
        tick(); tick();
        check("t4.drop_pulse", 32'(drop_pulse), 32'd1);
        check_slot("t4.drop.s0", 4'd0, 1'b1, "A", 9'd8);
        check_slot("t4.drop.s3", 4'd3, 1'b1, "D", 9'd2);
        tick();
        check("t4.nodrop", 32'(drop_pulse), 32'd0);
        step(1'b1, 1'b1, "c");
        check("t4.both.hit", 32'(hit_pulse), 32'd1);
        check("t4.both.drop", 32'(drop_pulse), 32'd1);
        check_slot("t4.both.s2", 4'd2, 1'b0, 8'h00, 9'd0);
        set_gen("E", 3'd0, 9'd7, 10'd0);
        tick(); tick();
        check_slot("t4.reuse.s2", 4'd2, 1'b1, "E", 9'd7);
        tick();
        check_slot("t4.spd0.s2", 4'd2, 1'b1, "E", 9'd8);
        rd_idx = 4'd5;
        #1;
        check("t4.rd_oob", 32'(rd_active), 32'd0);

        // Hit beats miss in the same frame; reset mid-play
        do_reset();
        set_gen("H", 3'd1, 9'd455, 10'd3);
        tick(); tick();
        check_slot("t5.spawn.s0", 4'd0, 1'b1, "H", 9'd455);
        step(1'b1, 1'b1, "h");
        check("t5.hit_pulse", 32'(hit_pulse), 32'd1);
        check("t5.miss_pulse", 32'(miss_pulse), 32'd0);
        check("t5.misses", 32'(misses), 32'd0);
        check("t5.score", 32'(score), 32'd1);
        tick();
        tick();
        check("t5.miss.misses", 32'(misses), 32'd1);
        set_gen("H", 3'd1, 9'd100, 10'd3);
        tick();
        @(negedge clk);
        rst_n      = 1'b0;
        frame_tick = 1'b1;
        key_valid  = 1'b1;
        key_ch     = "h";
        @(negedge clk);
        frame_tick = 1'b0;
        key_valid  = 1'b0;
        check("t5.rst.score", 32'(score), 32'd0);
        check("t5.rst.misses", 32'(misses), 32'd0);
        check("t5.rst.pulses", {28'd0, hit_pulse, wrong_pulse, miss_pulse, drop_pulse}, 32'd0);
        check_slot("t5.rst.s0", 4'd0, 1'b0, 8'h00, 9'd0);
        rst_n = 1'b1;
        tick();
        check_slot("t5.rst.cnt", 4'd0, 1'b0, 8'h00, 9'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
